// File: rtl/student_pkg.sv
// Shared types and constants for the student_ arithmetic blocks.
// Latency: none (declarations only).
// Backpressure: n/a.
package student_pkg;

  localparam int MULT_W = 16;

  // 2'd3 is never produced; the multiplier treats it as IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/student_mult16_if.sv
// Request/result bundle between a multiplier client and student_mult16.
// Latency: none (wires only).
// Backpressure: client may only expect start to be taken while ready=1.
interface student_mult16_if;
  import student_pkg::*;

  logic                  start;
  logic [MULT_W-1:0]     a;
  logic [MULT_W-1:0]     b;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [2*MULT_W-1:0]   product;

  modport master (output start, a, b, input ready, busy, done, product);
  modport slave  (input start, a, b, output ready, busy, done, product);
endinterface

// File: rtl/student_add16.sv
// 16-bit ripple-carry adder with carry out, one full-adder cell per bit.
// Latency: combinational.
// Backpressure: none.
module student_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = 1'b0;

  // Full-adder cells chained through c.
  for (genvar i = 0; i < 16; i++) begin : g_fa
    logic p;
    assign p      = a[i] ^ b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
  end

  assign cout = c[16];

endmodule

// File: rtl/student_and16.sv
// 16-bit bitwise AND gate bank, used to gate the multiplicand per step.
// Latency: combinational.
// Backpressure: none.
module student_and16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  assign y = a & b;

endmodule

// File: rtl/student_mult16.sv
// Sequential unsigned 16x16->32 shift-add multiplier, one partial product per cycle.
// Latency: accept edge N -> done high after edge N+16 -> ready again after edge N+17.
// Backpressure: start only taken in IDLE (ready=1); ignored in RUN/DONE.
module student_mult16
  import student_pkg::*;
#(
  parameter int WIDTH = MULT_W,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  student_mult16_if.slave  bus
);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [2*WIDTH-1:0] product;
  logic               ready_r;
  logic               busy_r;
  logic               done_r;

  logic [WIDTH-1:0]   pp;
  logic [WIDTH-1:0]   sum;
  logic               cout;

  // Partial product: multiplicand gated by the current multiplier LSB.
  student_and16 u_and (
    .a (mcand),
    .b ({WIDTH{lo[0]}}),
    .y (pp)
  );

  // Accumulate into the upper half; carry is kept by the right shift below.
  student_add16 u_add (
    .a    (hi),
    .b    (pp),
    .s    (sum),
    .cout (cout)
  );

  assign bus.ready   = ready_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product;

  // FSM, iteration counter, working registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      product <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          hi    <= {cout, sum[WIDTH-1:1]};
          lo    <= {sum[0], lo[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH-1)) begin
            state   <= S_DONE;
            product <= {cout, sum, lo[WIDTH-1:1]};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          // IDLE (and the unused encoding): wait for a request.
          if (bus.start) begin
            mcand   <= bus.a;
            hi      <= '0;
            lo      <= bus.b;
            count   <= '0;
            state   <= S_RUN;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
